// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decode arbiter: state encoding,
// busy counter sizing and the rotating first-one search.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned BUSY_W = 16;
  localparam logic [BUSY_W-1:0] BUSY_SAT = 16'hFFFF;

  // Widest requester vector the search supports (N up to 8).
  localparam int unsigned MAX_REQ = 256;

  // Rotate priority to start just after 'last', then take the first set bit.
  // Returns 'last' unchanged when no request is pending.
  function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        last,
                                          input int unsigned        n_req);
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = last + i;
      if (idx >= n_req) idx = idx - n_req;
      if (!found && (i <= n_req) && req[idx[7:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder.sv
// Shared N-to-2^N one-hot decoder with enable; output is all-zero when en is low.
module decoder #(
  parameter int N = 2
) (
  input  logic              en,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] op
);

  always_comb begin
    op = '0;
    if (en) op[a] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 2^N requesters; grant held until released, one-hot
// grant produced by the shared decoder. Optional hold limit: ARB_TIMEOUT_EN.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [(1<<N)-1:0] req,
  output logic [(1<<N)-1:0] gnt,
  output logic [N-1:0]      gnt_idx,
  output logic              gnt_valid,
  output logic [BUSY_W-1:0] busy_cycles,
  output logic              timeout
);

  localparam int REQ = 1 << N;
  localparam logic [N-1:0] LAST_INIT = N'(REQ - 1);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("rr_decode_arbiter: N must be in 1..8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("rr_decode_arbiter: MAX_HOLD must be in 1..65535");
  end

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_idx_q, gnt_idx_d;
  logic [N-1:0]      last_q, last_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [BUSY_W-1:0] busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [BUSY_W-1:0] HOLD_LIMIT = BUSY_W'(MAX_HOLD);
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_idx_d   = N'(rr_next(MAX_REQ'(req), 32'(last_q), REQ));
          last_d      = gnt_idx_d;
          gnt_valid_d = 1'b1;
          busy_d      = BUSY_W'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          busy_d      = '0;
        end
`ifdef ARB_TIMEOUT_EN
        // Forced revoke; last already holds the revoked index so it goes last.
        else if (busy_q == HOLD_LIMIT) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          busy_d      = '0;
          timeout_d   = 1'b1;
        end
`endif
        else if (busy_q != BUSY_SAT) begin
          busy_d = busy_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      last_q      <= LAST_INIT;
      gnt_valid_q <= 1'b0;
      busy_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt_idx     = gnt_idx_q;
  assign gnt_valid   = gnt_valid_q;
  assign busy_cycles = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

  decoder #(.N(N)) u_decoder (
    .en (gnt_valid_q),
    .a  (gnt_idx_q),
    .op (gnt)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus random
// requests, all compared against a behavioural round-robin model.
module tb_rr_decode_arbiter;

  localparam int N        = 2;
  localparam int REQ      = 1 << N;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [REQ-1:0] req = '0;
  logic [REQ-1:0] gnt;
  logic [N-1:0]   gnt_idx;
  logic           gnt_valid;
  logic [15:0]    busy_cycles;
  logic           timeout;

  int testCount = 0;
  int failCount = 0;

  int m_valid, m_idx, m_last, m_busy, m_timeout;

  rr_decode_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .busy_cycles (busy_cycles),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: state of the arbiter expressed as plain integers.
  task automatic modelReset();
    m_valid = 0; m_idx = 0; m_last = REQ - 1; m_busy = 0; m_timeout = 0;
  endtask

  task automatic modelStep(input logic [REQ-1:0] r);
    int c;
    bit found;
    m_timeout = 0;
    if (m_valid == 0) begin
      found = 0;
      for (int k = 1; k <= REQ; k++) begin
        c = (m_last + k) % REQ;
        if (!found && r[c]) begin
          found = 1; m_idx = c; m_last = c; m_valid = 1; m_busy = 1;
        end
      end
    end else if (!r[m_idx]) begin
      m_valid = 0; m_busy = 0;
    end else if (TIMEOUT_ON && m_busy == MAX_HOLD) begin
      m_valid = 0; m_busy = 0; m_timeout = 1;
    end else if (m_busy < 65535) begin
      m_busy = m_busy + 1;
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [REQ-1:0] eg;
    eg = (m_valid != 0) ? (REQ'(1) << m_idx) : '0;
    checkEq({tag, ".gnt"},         32'(gnt),         32'(eg));
    checkEq({tag, ".gnt_idx"},     32'(gnt_idx),     32'(m_idx));
    checkEq({tag, ".gnt_valid"},   32'(gnt_valid),   32'(m_valid));
    checkEq({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(m_busy));
    checkEq({tag, ".timeout"},     32'(timeout),     32'(m_timeout));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic applyStimulus(input logic [REQ-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int order[5];
    logic [REQ-1:0] r;
    order = '{0, 1, 2, 3, 0};

    resetDut();

    repeat (5) applyStimulus(4'b0000, "idle");

    for (int g = 0; g < 5; g++) begin
      applyStimulus(4'b1111, "rotate");
      checkEq("rotate_order", 32'(gnt), 32'(REQ'(1) << order[g]));
      applyStimulus(4'b1111, "rotate_hold");
      applyStimulus(4'b1111, "rotate_hold");
      applyStimulus(4'b1111 & ~(REQ'(1) << order[g]), "rotate_release");
      checkEq("rotate_bubble", 32'(gnt), 32'(0));
    end

    applyStimulus(4'b1000, "single3");
    checkEq("single3_gnt", 32'(gnt), 32'(4'b1000));
    applyStimulus(4'b0000, "single3_release");
    applyStimulus(4'b1001, "wrap");
    checkEq("wrap_gnt", 32'(gnt), 32'(4'b0001));
    applyStimulus(4'b0000, "wrap_release");

    resetDut();
    applyStimulus(4'b0100, "hold2");
    applyStimulus(4'b0100, "hold2");
    checkEq("hold2_gnt", 32'(gnt), 32'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkEq("async_reset_gnt", 32'(gnt), 32'(0));
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, "post_reset");
    checkEq("post_reset_idx", 32'(gnt_idx), 32'(0));
    applyStimulus(4'b0000, "post_reset_release");

    resetDut();
    repeat (12) applyStimulus(4'b0011, "hold_limit");
    applyStimulus(4'b0000, "hold_limit_release");

    r = '0;
    repeat (400) begin
      if ($urandom_range(3) == 0) r = REQ'($urandom);
      applyStimulus(r, "random");
    end

    applyStimulus(4'b0000, "sat_idle");
    repeat (65540) applyStimulus(4'b0001, "saturate");
    applyStimulus(4'b0000, "sat_release");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one resource among 2^N requesters.
- Selects a winner index, then drives the existing `decoder` block (parameter N) to produce the one-hot grant vector.
- Holds the grant until the winner releases it.
- Sits between requesting agents and any resource currently addressed through a one-hot decoder select.

Parameters:
- N, 2, grant index width; requester count REQ = 1<<N.
- MAX_HOLD, 16, maximum grant hold cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  REQ  per-requester request; level, held until served.
- gnt  output  REQ  one-hot grant, decoder output; all-zero when idle.
- gnt_idx  output  N  encoded index of the current grant holder.
- gnt_valid  output  1  high while any grant is held; drives decoder `en`.
- busy_cycles  output  16  cycles the current grant has been held; saturates at 16'hFFFF.
- timeout  output  1  one-cycle pulse on forced revoke; constant 0 without the macro.

Behaviour:
- Reset (asynchronous, rst_n low), applies immediately:
  - state=IDLE, gnt_valid=0, gnt=0, gnt_idx=0, busy_cycles=0, timeout=0.
  - last pointer = REQ-1, so requester 0 has first priority.
- States:
  - IDLE: no grant held.
  - GRANT: grant held by gnt_idx.
- IDLE with req != 0, at the next edge:
  - Winner = first set bit searching last+1, last+2, … modulo REQ.
  - gnt_idx <= winner, last <= winner, gnt_valid <= 1, state <= GRANT, busy_cycles <= 1.
- IDLE with req == 0: remain in IDLE, all outputs unchanged.
- Latency: req asserted before edge k gives gnt visible after edge k (1 cycle).
- GRANT:
  - While req[gnt_idx]=1: hold; busy_cycles increments each edge, saturating.
  - When req[gnt_idx]=0 at an edge: state <= IDLE, gnt_valid <= 0, busy_cycles <= 0.
  - Exactly one bubble cycle with gnt=0 separates consecutive grants.
  - Arbitration is never evaluated in GRANT; other requests wait.
- gnt derives from registered gnt_idx/gnt_valid through the decoder (combinational only), so gnt is glitch-free relative to clk.
- gnt is always one-hot or zero.
- gnt_idx holds its last value while in IDLE.
- Request changes from non-holders during GRANT have no effect.
- If a requester drops req in IDLE before being granted, it is simply not selected; no memory of past requests is kept.
- Single persistent requester: re-granted after each bubble, since it is the only candidate.
- Wrap-around: last=REQ-1 with req[0]=1 selects index 0.
- Reset mid-GRANT: grant removed immediately and asynchronously; pointer returns to REQ-1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined, in GRANT when busy_cycles == MAX_HOLD with req[gnt_idx] still high, at the next edge:
  - Forced revoke: state <= IDLE, gnt_valid <= 0, busy_cycles <= 0, timeout <= 1 for exactly one cycle.
  - last keeps the revoked index, so the next arbitration skips it first (fairness).
  - If the holder releases in the same cycle the limit is reached, treat it as a normal release: timeout stays 0.
- Undefined: no hold limit, timeout tied to 0, MAX_HOLD ignored.

Decomposition:
- Shared package `arb_pkg`:
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Constant BUSY_W=16 and saturation value.
  - Function for round-robin next-index search (priority rotate, then first-one).
- Sub-module: instantiate existing `decoder` #(.N(N)), with en=gnt_valid, a=gnt_idx, op=gnt. No new decoder is written.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, busy_cycles=0 throughout.
- req=4'b1111 held, each holder drops its req for one cycle after 3 grant cycles, then reasserts -> grant order 0,1,2,3,0; gnt one-hot 0001,0010,0100,1000,0001; one idle bubble between grants.
- req=4'b1000 only -> gnt=1000 one cycle after the request. Holder drops req, then req=4'b1001 -> gnt=0001, confirming wrap-around from last=3 to 0.
- Grant held on index 2, rst_n pulsed low mid-cycle -> gnt=0000 immediately, no clock needed. After release with req=4'b1111 -> first grant is index 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held continuously:
  - Index 0 is granted; revoked after busy_cycles reaches 4.
  - timeout pulses one cycle; next grant is index 1.
  - Without the macro, index 0 holds indefinitely and timeout stays 0.
- N=3, req=8'b1010_0000 after last=5 -> index 7 granted. Holder releases -> next grant is index 5.
